// File: rtl/fft8_flow_ctrl.sv
// Issue/flow controller for the pipelined 8-point FFT datapath: frame assembly, credit-gated launch,
// in-flight tracking. Optional twiddle ROM for 64-point first pass is enabled by FFT8_CTRL_TWROM_EN.
module fft8_flow_ctrl #(
  parameter int N       = 28,
  parameter int LAT     = 4,
  parameter int CREDITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   in_data,
  input  logic             cfg_ifft,
  output logic [2*N-1:0]   data0,
  output logic [2*N-1:0]   data1,
  output logic [2*N-1:0]   data2,
  output logic [2*N-1:0]   data3,
  output logic [2*N-1:0]   data4,
  output logic [2*N-1:0]   data5,
  output logic [2*N-1:0]   data6,
  output logic [2*N-1:0]   data7,
  output logic [31:0]      w1,
  output logic [31:0]      w2,
  output logic [31:0]      w3,
  output logic [31:0]      w4,
  output logic [31:0]      w5,
  output logic [31:0]      w6,
  output logic [31:0]      w7,
  output logic             ifft,
  output logic             stall,
  output logic             out_valid,
  output logic             out_ifft,
  output logic [2:0]       out_frm,
  input  logic             cr_ret,
  output logic             err_credit
);

  localparam logic [3:0]  CR_MAX = 4'(CREDITS);
  localparam logic [31:0] TW_ONE = 32'h4000_0000;

  logic [2*N-1:0] r_buf [8];
  logic [2:0]     r_wptr;
  logic           r_buf_full;
  logic           r_frame_mode;
  logic [LAT-1:0] r_vs;
  logic [3:0]     r_tag [LAT];
  logic [2:0]     r_frm_cnt;
  logic [3:0]     r_credit_cnt;
  logic [2*N-1:0] r_data [8];
  logic           r_ifft;
  logic           r_stall;
  logic           r_out_valid;
  logic           r_out_ifft;
  logic [2:0]     r_out_frm;
  logic           r_err_credit;

  logic w_pipe_empty;
  logic w_launch;
  logic w_accept;

  // A frame of a different mode may only enter an empty pipe, so ifft never flips under live data.
  assign w_pipe_empty = (r_vs == '0);
  assign w_launch     = r_buf_full && (r_credit_cnt != 4'd0) &&
                        (w_pipe_empty || (r_frame_mode == r_ifft));
  assign in_ready     = ~r_buf_full | w_launch;
  assign w_accept     = in_valid & in_ready;

  // Stage: assembly buffer
  always_ff @(posedge clk) begin
    if (w_accept) r_buf[r_wptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr       <= '0;
      r_buf_full   <= 1'b0;
      r_frame_mode <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wptr <= r_wptr + 3'd1;
        if (r_wptr == 3'd0) r_frame_mode <= cfg_ifft;
      end
      if (w_accept && (r_wptr == 3'd7)) r_buf_full <= 1'b1;
      else if (w_launch)                r_buf_full <= 1'b0;
    end
  end

  // Stage: launch into the datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) r_data[i] <= '0;
      r_ifft    <= 1'b0;
      r_frm_cnt <= '0;
    end else if (w_launch) begin
      for (int i = 0; i < 8; i++) r_data[i] <= r_buf[i];
      r_ifft    <= r_frame_mode;
      r_frm_cnt <= r_frm_cnt + 3'd1;
    end
  end

  // Stage: in-flight tracking and result flagging
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs        <= '0;
      for (int i = 0; i < LAT; i++) r_tag[i] <= '0;
      r_stall     <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_ifft  <= 1'b0;
      r_out_frm   <= '0;
    end else begin
      r_vs     <= {r_vs[LAT-2:0], w_launch};
      r_tag[0] <= {r_frame_mode, r_frm_cnt};
      for (int i = 1; i < LAT; i++) r_tag[i] <= r_tag[i-1];
      r_stall     <= ~r_vs[LAT-2];
      r_out_valid <= r_vs[LAT-1];
      if (r_vs[LAT-1]) begin
        r_out_ifft <= r_tag[LAT-1][3];
        r_out_frm  <= r_tag[LAT-1][2:0];
      end
    end
  end

  // Stage: downstream credits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credit_cnt <= CR_MAX;
      r_err_credit <= 1'b0;
    end else begin
      if (cr_ret && (r_credit_cnt == CR_MAX)) r_err_credit <= 1'b1;
      if (w_launch && !cr_ret)
        r_credit_cnt <= r_credit_cnt - 4'd1;
      else if (!w_launch && cr_ret && (r_credit_cnt != CR_MAX))
        r_credit_cnt <= r_credit_cnt + 4'd1;
    end
  end

`ifdef FFT8_CTRL_TWROM_EN
  // Quarter-wave table: round(16384*cos(2*pi*r/64)), r = 0..16.
  function automatic logic signed [15:0] cos_q(input logic [4:0] r);
    case (r)
      5'd0:    return 16'sd16384;
      5'd1:    return 16'sd16305;
      5'd2:    return 16'sd16069;
      5'd3:    return 16'sd15679;
      5'd4:    return 16'sd15137;
      5'd5:    return 16'sd14449;
      5'd6:    return 16'sd13623;
      5'd7:    return 16'sd12665;
      5'd8:    return 16'sd11585;
      5'd9:    return 16'sd10394;
      5'd10:   return 16'sd9102;
      5'd11:   return 16'sd7723;
      5'd12:   return 16'sd6270;
      5'd13:   return 16'sd4756;
      5'd14:   return 16'sd3196;
      5'd15:   return 16'sd1606;
      default: return 16'sd0;
    endcase
  endfunction

  function automatic logic [31:0] tw_word(input logic [5:0] idx);
    logic [4:0]         r;
    logic [4:0]         rc;
    logic signed [15:0] re;
    logic signed [15:0] im;
    r  = {1'b0, idx[3:0]};
    rc = 5'd16 - r;
    case (idx[5:4])
      2'd0:    begin re =  cos_q(r);  im = -cos_q(rc); end
      2'd1:    begin re = -cos_q(rc); im = -cos_q(r);  end
      2'd2:    begin re = -cos_q(r);  im =  cos_q(rc); end
      default: begin re =  cos_q(rc); im =  cos_q(r);  end
    endcase
    return {re, im};
  endfunction

  logic [31:0] r_w [1:7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k < 8; k++) r_w[k] <= TW_ONE;
    end else if (w_launch) begin
      for (int k = 1; k < 8; k++) r_w[k] <= tw_word(6'(k) * {3'b000, r_frm_cnt});
    end
  end

  assign w1 = r_w[1];
  assign w2 = r_w[2];
  assign w3 = r_w[3];
  assign w4 = r_w[4];
  assign w5 = r_w[5];
  assign w6 = r_w[6];
  assign w7 = r_w[7];
`else
  assign w1 = TW_ONE;
  assign w2 = TW_ONE;
  assign w3 = TW_ONE;
  assign w4 = TW_ONE;
  assign w5 = TW_ONE;
  assign w6 = TW_ONE;
  assign w7 = TW_ONE;
`endif

  assign data0      = r_data[0];
  assign data1      = r_data[1];
  assign data2      = r_data[2];
  assign data3      = r_data[3];
  assign data4      = r_data[4];
  assign data5      = r_data[5];
  assign data6      = r_data[6];
  assign data7      = r_data[7];
  assign ifft       = r_ifft;
  assign stall      = r_stall;
  assign out_valid  = r_out_valid;
  assign out_ifft   = r_out_ifft;
  assign out_frm    = r_out_frm;
  assign err_credit = r_err_credit;

endmodule

// File: tb/tb_fft8_flow_ctrl.sv
// Directed self-checking bench for fft8_flow_ctrl (default build; twiddle expectations follow FFT8_CTRL_TWROM_EN).
module tb_fft8_flow_ctrl;

  localparam int N = 28;

`ifdef FFT8_CTRL_TWROM_EN
  localparam logic [31:0] EXP_W1_M1 = 32'h3FB1_F9BA;
  localparam logic [31:0] EXP_W4_M2 = 32'h2D41_D2BF;
  localparam logic [31:0] EXP_W4_M4 = 32'h0000_C000;
`else
  localparam logic [31:0] EXP_W1_M1 = 32'h4000_0000;
  localparam logic [31:0] EXP_W4_M2 = 32'h4000_0000;
  localparam logic [31:0] EXP_W4_M4 = 32'h4000_0000;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           cfg_ifft = 1'b0;
  logic           cr_ret = 1'b0;
  logic [2*N-1:0] in_data = '0;
  logic           in_ready;
  logic [2*N-1:0] dat [8];
  logic [31:0]    wv [7];
  logic           ifft, stall, out_valid, out_ifft, err_credit;
  logic [2:0]     out_frm;

  int checks = 0;
  int errors = 0;

  int         ov_steps [$];
  int         st_steps [$];
  logic [2:0] frms [$];
  bit         ready_drop;
  logic       ret_next;

  fft8_flow_ctrl #(.N(N), .LAT(4), .CREDITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cfg_ifft(cfg_ifft),
    .data0(dat[0]), .data1(dat[1]), .data2(dat[2]), .data3(dat[3]),
    .data4(dat[4]), .data5(dat[5]), .data6(dat[6]), .data7(dat[7]),
    .w1(wv[0]), .w2(wv[1]), .w3(wv[2]), .w4(wv[3]), .w5(wv[4]), .w6(wv[5]), .w7(wv[6]),
    .ifft(ifft), .stall(stall), .out_valid(out_valid), .out_ifft(out_ifft), .out_frm(out_frm),
    .cr_ret(cr_ret), .err_credit(err_credit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; cr_ret = 1'b0; cfg_ifft = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic [55:0] smp(input int f, input int i);
    logic [27:0] re;
    logic [27:0] im;
    re = 28'h800_0000 | 28'(f * 256 + i);
    im = 28'(i * 1000 + f + 1);
    return {re, im};
  endfunction

  initial begin
    // ---- reset state ----
    do_reset();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_stall", 64'(stall), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_ifft", 64'(ifft), 64'd0);
    check("rst_data0", 64'(dat[0]), 64'd0);
    check("rst_out_frm", 64'(out_frm), 64'd0);
    check("rst_err", 64'(err_credit), 64'd0);
    check("rst_w1", 64'(wv[0]), 64'h4000_0000);
    check("rst_credit", 64'(dut.r_credit_cnt), 64'd4);

    // ---- single frame ----
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = smp(0, i); cfg_ifft = 1'b0;
      step();
    end
    in_valid = 1'b0;
    check("t1_no_early_launch", 64'(dat[0]), 64'd0);
    check("t1_ready_full_launch", 64'(in_ready), 64'd1);
    step();
    for (int i = 0; i < 8; i++) check($sformatf("t1_data%0d", i), 64'(dat[i]), 64'(smp(0, i)));
    for (int k = 0; k < 7; k++) check($sformatf("t1_w%0d", k + 1), 64'(wv[k]), 64'h4000_0000);
    check("t1_credit", 64'(dut.r_credit_cnt), 64'd3);
    check("t1_ifft", 64'(ifft), 64'd0);
    check("t1_stall_e0", 64'(stall), 64'd1);
    step(); check("t1_stall_e1", 64'(stall), 64'd1);
    step(); check("t1_stall_e2", 64'(stall), 64'd1);
    step(); check("t1_stall_e3", 64'(stall), 64'd0);
    check("t1_ov_e3", 64'(out_valid), 64'd0);
    step(); check("t1_stall_e4", 64'(stall), 64'd1);
    check("t1_ov_e4", 64'(out_valid), 64'd1);
    check("t1_frm", 64'(out_frm), 64'd0);
    check("t1_oifft", 64'(out_ifft), 64'd0);
    step(); check("t1_ov_e5", 64'(out_valid), 64'd0);
    cr_ret = 1'b1; step(); cr_ret = 1'b0;
    check("t1_credit_ret", 64'(dut.r_credit_cnt), 64'd4);
    check("t1_err", 64'(err_credit), 64'd0);

    // ---- streaming, 3 frames ----
    do_reset();
    ready_drop = 1'b0; ret_next = 1'b0;
    for (int s = 1; s <= 36; s++) begin
      if (s <= 24) begin
        in_valid = 1'b1; in_data = smp((s - 1) / 8, (s - 1) % 8);
        if (!in_ready) ready_drop = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      cr_ret = ret_next;
      step();
      if (!stall) st_steps.push_back(s);
      if (out_valid) begin ov_steps.push_back(s); frms.push_back(out_frm); end
      ret_next = out_valid;
      if (s == 16) check("t2_no_early_launch", 64'(dat[0]), 64'(smp(0, 0)));
      if (s == 9 || s == 17 || s == 25) begin
        check($sformatf("t2_data0_s%0d", s), 64'(dat[0]), 64'(smp((s - 9) / 8, 0)));
        check($sformatf("t2_data7_s%0d", s), 64'(dat[7]), 64'(smp((s - 9) / 8, 7)));
      end
    end
    cr_ret = 1'b0;
    check("t2_ready_held", 64'(ready_drop), 64'd0);
    check("t2_stall_count", 64'(st_steps.size()), 64'd3);
    check("t2_ov_count", 64'(ov_steps.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t2_stall_step%0d", i), 64'((i < st_steps.size()) ? st_steps[i] : -1), 64'(12 + 8 * i));
      check($sformatf("t2_ov_step%0d", i), 64'((i < ov_steps.size()) ? ov_steps[i] : -1), 64'(13 + 8 * i));
      check($sformatf("t2_frm%0d", i), 64'((i < frms.size()) ? frms[i] : 3'd7), 64'(i));
    end
    check("t2_credit_end", 64'(dut.r_credit_cnt), 64'd4);

    // ---- credit stall ----
    do_reset();
    for (int s = 1; s <= 40; s++) begin
      in_valid = 1'b1; in_data = smp((s - 1) / 8, (s - 1) % 8);
      step();
      if (s == 17) check("t3_w1_m1", 64'(wv[0]), 64'(EXP_W1_M1));
      if (s == 25) check("t3_w4_m2", 64'(wv[3]), 64'(EXP_W4_M2));
    end
    in_valid = 1'b0;
    check("t3_ready_drop", 64'(in_ready), 64'd0);
    check("t3_credit_zero", 64'(dut.r_credit_cnt), 64'd0);
    step(); step();
    check("t3_ready_still_low", 64'(in_ready), 64'd0);
    check("t3_held_data0", 64'(dat[0]), 64'(smp(3, 0)));
    cr_ret = 1'b1; step(); cr_ret = 1'b0;
    check("t3_ret_no_launch_yet", 64'(dat[0]), 64'(smp(3, 0)));
    check("t3_credit_one", 64'(dut.r_credit_cnt), 64'd1);
    check("t3_ready_up", 64'(in_ready), 64'd1);
    step();
    check("t3_launch5_data0", 64'(dat[0]), 64'(smp(4, 0)));
    check("t3_credit_after5", 64'(dut.r_credit_cnt), 64'd0);
    check("t3_w4_m4", 64'(wv[3]), 64'(EXP_W4_M4));
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = smp(5, i);
      step();
    end
    in_valid = 1'b0;
    check("t3_ready_low6", 64'(in_ready), 64'd0);
    cr_ret = 1'b1;
    step();
    step();
    cr_ret = 1'b0;
    check("t3_launch6_data0", 64'(dat[0]), 64'(smp(5, 0)));
    check("t3_credit_coincide", 64'(dut.r_credit_cnt), 64'd1);
    cr_ret = 1'b1; step(); step(); step(); cr_ret = 1'b0;
    check("t3_credit_full", 64'(dut.r_credit_cnt), 64'd4);
    check("t3_err_clear", 64'(err_credit), 64'd0);
    cr_ret = 1'b1; step(); cr_ret = 1'b0;
    check("t3_err_set", 64'(err_credit), 64'd1);
    check("t3_credit_sat", 64'(dut.r_credit_cnt), 64'd4);

    // ---- mode change ----
    do_reset();
    for (int s = 1; s <= 24; s++) begin
      if (s <= 16) begin
        in_valid = 1'b1; in_data = smp((s - 1) / 8, (s - 1) % 8);
        cfg_ifft = (s == 2 || s == 9);
      end else begin
        in_valid = 1'b0; cfg_ifft = 1'b0;
      end
      step();
      if (s == 9) begin
        check("t4_a_launch", 64'(dat[0]), 64'(smp(0, 0)));
        check("t4_a_ifft", 64'(ifft), 64'd0);
      end
      if (s == 13) begin
        check("t4_a_ov", 64'(out_valid), 64'd1);
        check("t4_a_oifft", 64'(out_ifft), 64'd0);
      end
      if (s == 16) begin
        check("t4_b_not_early", 64'(dat[0]), 64'(smp(0, 0)));
        check("t4_ifft_hold", 64'(ifft), 64'd0);
      end
      if (s == 17) begin
        check("t4_b_launch", 64'(dat[0]), 64'(smp(1, 0)));
        check("t4_b_ifft", 64'(ifft), 64'd1);
      end
      if (s == 21) begin
        check("t4_b_ov", 64'(out_valid), 64'd1);
        check("t4_b_oifft", 64'(out_ifft), 64'd1);
        check("t4_b_frm", 64'(out_frm), 64'd1);
      end
    end

    // ---- reset mid-frame ----
    do_reset();
    for (int s = 1; s <= 13; s++) begin
      in_valid = 1'b1; in_data = smp((s - 1) / 8, (s - 1) % 8);
      step();
    end
    in_valid = 1'b0;
    check("t5_pre_ov", 64'(out_valid), 64'd1);
    check("t5_pre_credit", 64'(dut.r_credit_cnt), 64'd3);
    rst_n = 1'b0;
    #2;
    check("t5_async_stall", 64'(stall), 64'd1);
    check("t5_async_ov", 64'(out_valid), 64'd0);
    check("t5_async_credit", 64'(dut.r_credit_cnt), 64'd4);
    check("t5_async_ready", 64'(in_ready), 64'd1);
    step(); step();
    rst_n = 1'b1;
    for (int s = 1; s <= 16; s++) begin
      if (s <= 8) begin
        in_valid = 1'b1; in_data = smp(7, s - 1);
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (s == 9)
        for (int i = 0; i < 8; i++) check($sformatf("t5_data%0d", i), 64'(dat[i]), 64'(smp(7, i)));
      if (s == 13) begin
        check("t5_ov", 64'(out_valid), 64'd1);
        check("t5_frm", 64'(out_frm), 64'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
